// File: rtl/uart_parity_rx.sv
// 8-bit UART receiver with one parity bit (even or odd) and framing check.
// Reassembles LSB-first bytes and reports parity/stop status per frame.
module uart_parity_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift;
    logic          perr_pend;

    logic rx_s1;
    logic rx_s2;
    logic rx_prev;
    logic fall;
    logic bit_done;
    logic half_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign fall      = rx_prev & ~rx_s2;
    assign bit_done  = (cnt == BIT_LAST);
    assign half_done = (cnt == HALF_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bitn       <= 3'd0;
            shift      <= 8'h00;
            perr_pend  <= 1'b0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (fall) begin
                        state <= START;
                        bitn  <= 3'd0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (half_done) begin
                        cnt <= '0;
                        // A high mid-start sample is a line glitch, not a frame
                        if (rx_s2) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shift <= {rx_s2, shift[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state <= PARITY;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        cnt       <= '0;
                        perr_pend <= rx_s2 ^ (^shift) ^ PARITY_ODD;
                        state     <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt        <= '0;
                        data       <= shift;
                        parity_err <= perr_pend;
                        frame_err  <= ~rx_s2;
                        data_valid <= 1'b1;
                        // A low stop bit may be a break: wait for idle line
                        if (rx_s2) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    cnt <= '0;
                    if (rx_s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_parity_rx.sv
// Scoreboard bench for uart_parity_rx: even and odd instances share one line.
// Frames are predicted from the byte, parity and stop bits actually sent.
module tb_uart_parity_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 3 + HALF + 10 * CPB + 1;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] d_a [2];
    logic       dv_a[2];
    logic       pe_a[2];
    logic       fe_a[2];
    logic       bz_a[2];

    exp_t       q[2][$];
    int         cyc;
    int         checks;
    int         errors;
    int         dvcnt[2];
    int         sent;
    logic [7:0] last_d;
    logic       last_pe[2];
    logic       last_fe;

    uart_parity_rx #(
        .CLK_FREQ(16),
        .BAUD(1),
        .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(rxd),
        .data(d_a[0]),
        .data_valid(dv_a[0]),
        .parity_err(pe_a[0]),
        .frame_err(fe_a[0]),
        .busy(bz_a[0])
    );

    uart_parity_rx #(
        .CLK_FREQ(16),
        .BAUD(1),
        .PARITY_ODD(1'b1)
    ) dut_odd (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(rxd),
        .data(d_a[1]),
        .data_valid(dv_a[1]),
        .parity_err(pe_a[1]),
        .frame_err(fe_a[1]),
        .busy(bz_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every data_valid pulse must match the oldest predicted frame
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (dv_a[i]) begin
                    dvcnt[i]++;
                    if (q[i].size() == 0) begin
                        chk($sformatf("spurious_dv%0d", i), 32'(dv_a[i]), 0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk($sformatf("data%0d", i), 32'(d_a[i]), 32'(e.d));
                        chk($sformatf("perr%0d", i), 32'(pe_a[i]), 32'(e.pe));
                        chk($sformatf("ferr%0d", i), 32'(fe_a[i]), 32'(e.fe));
                        chk($sformatf("busy_dv%0d", i), 32'(bz_a[i]),
                            32'(e.fe));
                        chk($sformatf("latency%0d", i), 32'(cyc + 1 - e.t0),
                            32'(LAT));
                    end
                end
            end
        end
    end

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitp(input logic v);
        rxd = v;
        waitc(CPB);
    endtask

    task automatic send(input logic [7:0] b, input logic par,
                        input logic stp, input int hold);
        exp_t e;
        e.d  = b;
        e.fe = ~stp;
        e.t0 = cyc;
        for (int i = 0; i < 2; i++) begin
            // Correct parity bit makes the count of ones even (odd for i=1)
            e.pe = (par != ((($countones(b) + i) % 2) == 1));
            q[i].push_back(e);
            last_pe[i] = e.pe;
        end
        last_d  = b;
        last_fe = ~stp;
        sent++;
        bitp(1'b0);
        for (int k = 0; k < 8; k++) bitp(b[k]);
        bitp(par);
        bitp(stp);
        if (!stp) begin
            waitc(hold);
            chk("busy_waithigh0", 32'(bz_a[0]), 1);
            chk("busy_waithigh1", 32'(bz_a[1]), 1);
            rxd = 1'b1;
            waitc(4);
            chk("busy_released0", 32'(bz_a[0]), 0);
            chk("busy_released1", 32'(bz_a[1]), 0);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] d,
                            input logic pe0, input logic pe1,
                            input logic fe);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_data"}, 32'(d_a[i]), 32'(d));
            chk({tag, "_perr"}, 32'(pe_a[i]), 32'(i == 0 ? pe0 : pe1));
            chk({tag, "_ferr"}, 32'(fe_a[i]), 32'(fe));
            chk({tag, "_busy"}, 32'(bz_a[i]), 0);
            chk({tag, "_dv"}, 32'(dv_a[i]), 0);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       par;
        logic       stp;
        checks   = 0;
        errors   = 0;
        sent     = 0;
        dvcnt[0] = 0;
        dvcnt[1] = 0;
        rxd      = 1'b1;
        rst_n    = 1'b0;
        waitc(3);
        chk_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        waitc(5);

        send(8'hA5, 1'b0, 1'b1, 0);
        waitc(4);
        send(8'hA5, 1'b1, 1'b1, 0);
        waitc(4);

        send(8'h3C, 1'b0, 1'b0, 24);
        send(8'h01, 1'b1, 1'b1, 0);
        waitc(20);

        rxd = 1'b0;
        waitc(4);
        rxd = 1'b1;
        waitc(10);
        chk_outs("glitch", last_d, last_pe[0], last_pe[1], last_fe);
        waitc(10);

        send(8'h00, 1'b0, 1'b1, 0);
        send(8'hFF, 1'b0, 1'b1, 0);
        waitc(6);

        for (int n = 0; n < 30; n++) begin
            b   = 8'($urandom);
            par = (^b) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 4) != 0);
            send(b, par, stp, 8);
            waitc($urandom_range(0, 5));
        end
        waitc(6);

        rxd = 1'b0;
        waitc(CPB);
        b = 8'h5A;
        for (int k = 0; k < 4; k++) bitp(b[k]);
        rxd = b[4];
        waitc(5);
        rst_n = 1'b0;
        #1;
        chk_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        waitc(3);
        rst_n = 1'b1;
        waitc(5);
        send(8'h5A, 1'b0, 1'b1, 0);

        for (int n = 0; n < 400; n++) begin
            if (q[0].size() == 0 && q[1].size() == 0) break;
            waitc(1);
        end
        chk("drain0", 32'(q[0].size()), 0);
        chk("drain1", 32'(q[1].size()), 0);
        chk("pulses0", 32'(dvcnt[0]), 32'(sent));
        chk("pulses1", 32'(dvcnt[1]), 32'(sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
